// File: rtl/cell_test_sequencer.sv
// Sequencer for the RV523 cell test boards: steps every input vector through NUM_CH cells in parallel,
// checks the synchronised outputs against a truth table and accumulates per-run results.
module cell_test_sequencer #(
    parameter int unsigned           NUM_IN        = 2,
    parameter int unsigned           NUM_CH        = 2,
    parameter int unsigned           SETTLE_CYCLES = 4,
    parameter logic [(2**NUM_IN)-1:0] TRUTH_TABLE  = 4'b0111,
    parameter int unsigned           CNT_W         = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              stop_on_fail_i,
    input  logic              loop_i,
    input  logic              abort_i,
    input  logic [NUM_CH-1:0] dut_out_i,
    output logic [NUM_IN-1:0] dut_in_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic [NUM_CH-1:0] fail_ch_o,
    output logic [NUM_IN-1:0] first_fail_vec_o,
    output logic [CNT_W-1:0]  err_count_o
);

    localparam int unsigned WIN     = SETTLE_CYCLES + 2;
    localparam int unsigned WIN_W   = $clog2(WIN);
    localparam int unsigned SUM_W   = CNT_W + 5;
    localparam logic [NUM_IN-1:0] LAST_VEC = '1;
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(WIN - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;

    state_t            state_q, state_d;
    logic [NUM_IN-1:0] vec_q, vec_d;
    logic [WIN_W-1:0]  win_q, win_d;
    logic              stop_q, stop_d;
    logic              loop_q, loop_d;
    logic              sweep_q, sweep_d;
    logic              pass_q, pass_d;
    logic [NUM_CH-1:0] fail_q, fail_d;
    logic [NUM_IN-1:0] ffv_q, ffv_d;
    logic [CNT_W-1:0]  err_q, err_d;
    logic [NUM_CH-1:0] sync1_q, sync2_q;

    logic [NUM_CH-1:0] mismatch;
    logic [4:0]        mmCount;
    logic [SUM_W-1:0]  errSum;
    logic [CNT_W-1:0]  errSat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= '0;
            win_q   <= '0;
            stop_q  <= 1'b0;
            loop_q  <= 1'b0;
            sweep_q <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= '0;
            ffv_q   <= '0;
            err_q   <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            win_q   <= win_d;
            stop_q  <= stop_d;
            loop_q  <= loop_d;
            sweep_q <= sweep_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            ffv_q   <= ffv_d;
            err_q   <= err_d;
            sync1_q <= dut_out_i;
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        win_d   = win_q;
        stop_d  = stop_q;
        loop_d  = loop_q;
        sweep_d = sweep_q;
        pass_d  = pass_q;
        fail_d  = fail_q;
        ffv_d   = ffv_q;
        err_d   = err_q;

        mismatch = sync2_q ^ {NUM_CH{TRUTH_TABLE[vec_q]}};
        mmCount  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            mmCount = mmCount + 5'(mismatch[i]);
        end
        errSum = SUM_W'(err_q) + SUM_W'(mmCount);
        errSat = (errSum > SUM_W'(CNT_MAX)) ? CNT_MAX : errSum[CNT_W-1:0];

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = SETTLE;
                    vec_d   = '0;
                    win_d   = '0;
                    stop_d  = stop_on_fail_i;
                    loop_d  = loop_i;
                    sweep_d = 1'b0;
                    pass_d  = 1'b0;
                    fail_d  = '0;
                    ffv_d   = '0;
                    err_d   = '0;
                end
            end
            SETTLE: begin
                // Abort wins even on the compare cycle, so an aborted window never contributes.
                if (abort_i) begin
                    state_d = DONE;
                end else if (win_q == WIN_LAST) begin
                    win_d  = '0;
                    err_d  = errSat;
                    fail_d = fail_q | mismatch;
                    if (fail_q == '0 && mismatch != '0) begin
                        ffv_d = vec_q;
                    end
                    if (stop_q && mismatch != '0) begin
                        state_d = DONE;
                    end else if (vec_q == LAST_VEC) begin
                        sweep_d = 1'b1;
                        vec_d   = '0;
                        if (!loop_q) begin
                            state_d = DONE;
                        end
                    end else begin
                        vec_d = vec_q + NUM_IN'(1);
                    end
                end else begin
                    win_d = win_q + WIN_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Registering pass on entry to DONE makes it valid alongside the done pulse.
        if (state_q == SETTLE && state_d == DONE) begin
            pass_d = sweep_d && (err_d == '0);
        end
    end

    assign busy_o           = (state_q == SETTLE);
    assign done_o           = (state_q == DONE);
    assign dut_in_o         = busy_o ? vec_q : '0;
    assign pass_o           = pass_q;
    assign fail_ch_o        = fail_q;
    assign first_fail_vec_o = ffv_q;
    assign err_count_o      = err_q;

endmodule

// File: tb/tb_cell_test_sequencer.sv
// Bench for cell_test_sequencer: directed scenarios plus randomised runs against a per-run outcome model
// built from per-channel cell truth tables.
module tb_cell_test_sequencer;

    localparam int NUM_IN = 2;
    localparam int NUM_CH = 2;
    localparam int SETTLE = 4;
    localparam int CNT_W  = 4;
    localparam int W      = SETTLE + 2;
    localparam int NV     = 4;
    localparam int CMAX   = 15;
    localparam logic [3:0] TT = 4'b0111;

    logic clk = 1'b0;
    logic rst_n, start, stopOnFail, loopEn, abort;
    logic [NUM_CH-1:0] dutOut, failCh;
    logic [NUM_IN-1:0] dutIn, firstFailVec;
    logic busy, done, pass;
    logic [CNT_W-1:0] errCount;
    logic [3:0] chTab [NUM_CH];

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    // Each cell is modelled as an arbitrary 4-entry table: ideal NAND2, stuck-at or a corrupted table.
    always_comb begin
        dutOut = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            dutOut[ch] = chTab[ch][dutIn];
        end
    end

    cell_test_sequencer #(
        .NUM_IN(NUM_IN), .NUM_CH(NUM_CH), .SETTLE_CYCLES(SETTLE),
        .TRUTH_TABLE(TT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .stop_on_fail_i(stopOnFail),
        .loop_i(loopEn), .abort_i(abort), .dut_out_i(dutOut), .dut_in_o(dutIn),
        .busy_o(busy), .done_o(done), .pass_o(pass), .fail_ch_o(failCh),
        .first_fail_vec_o(firstFailVec), .err_count_o(errCount)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Outcome of one run, walking windows in order: window k compares at cycle k*W after the start edge.
    task automatic modelRun(input bit stopEn, input bit loopOn, input int abortAt,
                            output int endC, output logic [3:0] eErr,
                            output logic [1:0] eFail, output logic [1:0] eFfv, output bit ePass);
        int err;
        int v;
        bit sweep;
        logic [1:0] mm;
        err = 0; sweep = 0; eFail = '0; eFfv = '0; endC = 0;
        for (int k = 1; k < 2000; k++) begin
            if (abortAt != 0 && k * W > abortAt) begin
                endC = abortAt + 1;
                break;
            end
            v = (k - 1) % NV;
            for (int ch = 0; ch < NUM_CH; ch++) mm[ch] = (chTab[ch][v] != TT[v]);
            err = err + $countones(mm);
            if (err > CMAX) err = CMAX;
            if (mm != 0 && eFail == 0) eFfv = 2'(v);
            eFail = eFail | mm;
            if (stopEn && mm != 0) begin
                endC = k * W + 1;
                break;
            end
            if (v == NV - 1) begin
                sweep = 1;
                if (!loopOn) begin
                    endC = k * W + 1;
                    break;
                end
            end
        end
        eErr  = 4'(err);
        ePass = sweep && (err == 0);
    endtask

    task automatic applyStimulus(input string name, input bit stopEn, input bit loopOn,
                                 input int abortAt, input int startPulse, input bit startInDone);
        int endC;
        logic [3:0] eErr;
        logic [1:0] eFail, eFfv;
        bit ePass;
        modelRun(stopEn, loopOn, abortAt, endC, eErr, eFail, eFfv, ePass);
        @(negedge clk);
        start = 1'b1; stopOnFail = stopEn; loopEn = loopOn; abort = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        start = 1'b0; stopOnFail = 1'($urandom); loopEn = 1'($urandom);
        for (int c = 1; c <= endC; c++) begin
            start = (c == startPulse) || (startInDone && c == endC);
            abort = (c == abortAt);
            if (c < endC) begin
                checkOutput({name, " busy"}, 32'(busy), 1);
                checkOutput({name, " done_early"}, 32'(done), 0);
                checkOutput({name, " dut_in"}, 32'(dutIn), ((c - 1) / W) % NV);
            end else begin
                checkOutput({name, " done"}, 32'(done), 1);
                checkOutput({name, " busy_in_done"}, 32'(busy), 0);
                checkOutput({name, " dut_in_idle"}, 32'(dutIn), 0);
                checkOutput({name, " pass"}, 32'(pass), 32'(ePass));
                checkOutput({name, " err_count"}, 32'(errCount), 32'(eErr));
                checkOutput({name, " fail_ch"}, 32'(failCh), 32'(eFail));
                checkOutput({name, " first_fail_vec"}, 32'(firstFailVec), 32'(eFfv));
            end
            @(posedge clk); #1;
        end
        start = 1'b0; abort = 1'b0;
        checkOutput({name, " done_pulse_end"}, 32'(done), 0);
        checkOutput({name, " no_restart"}, 32'(busy), 0);
        checkOutput({name, " err_hold"}, 32'(errCount), 32'(eErr));
        checkOutput({name, " pass_hold"}, 32'(pass), 32'(ePass));
    endtask

    function automatic int pickAbort(input int lo, input int hi);
        int a;
        a = $urandom_range(lo, hi);
        if (a % W == 0) a = a + 1;
        return a;
    endfunction

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int ab;
        rst_n = 1'b0; start = 1'b0; stopOnFail = 1'b0; loopEn = 1'b0; abort = 1'b0;
        chTab[0] = TT; chTab[1] = TT;
        #12;
        checkOutput("reset busy", 32'(busy), 0);
        checkOutput("reset done", 32'(done), 0);
        checkOutput("reset pass", 32'(pass), 0);
        checkOutput("reset dut_in", 32'(dutIn), 0);
        checkOutput("reset fail_ch", 32'(failCh), 0);
        checkOutput("reset ffv", 32'(firstFailVec), 0);
        checkOutput("reset err", 32'(errCount), 0);
        @(negedge clk); rst_n = 1'b1;

        applyStimulus("t1_ideal", 0, 0, 0, 8, 1);

        chTab[1] = 4'hF;
        applyStimulus("t2_ch1_sa1", 0, 0, 0, 0, 0);

        chTab[0] = 4'h0; chTab[1] = TT;
        applyStimulus("t3_stop_ch0_sa0", 1, 0, 0, 0, 0);

        chTab[0] = 4'h0; chTab[1] = 4'h0;
        applyStimulus("t4_loop_saturate", 0, 1, 75, 20, 0);

        chTab[0] = TT; chTab[1] = TT;
        applyStimulus("t5_loop_abort", 0, 1, 30, 0, 0);

        // Reset during vector 2 of a run that has already logged a vector-0 error.
        chTab[0] = 4'b0110; chTab[1] = TT;
        @(negedge clk); start = 1'b1; stopOnFail = 1'b0; loopEn = 1'b0;
        @(posedge clk); #1; start = 1'b0;
        repeat (13) @(posedge clk);
        #2;
        checkOutput("t6 pre_reset dut_in", 32'(dutIn), 2);
        checkOutput("t6 pre_reset err", 32'(errCount), 1);
        rst_n = 1'b0;
        #1;
        checkOutput("t6 reset busy", 32'(busy), 0);
        checkOutput("t6 reset done", 32'(done), 0);
        checkOutput("t6 reset dut_in", 32'(dutIn), 0);
        checkOutput("t6 reset err", 32'(errCount), 0);
        checkOutput("t6 reset fail_ch", 32'(failCh), 0);
        @(posedge clk); #1;
        checkOutput("t6 no_done_pulse", 32'(done), 0);
        @(negedge clk); rst_n = 1'b1;
        chTab[0] = TT;
        applyStimulus("t6_after_reset", 0, 0, 0, 10, 1);

        for (int n = 0; n < 24; n++) begin
            bit s, l;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                case ($urandom_range(0, 3))
                    0: chTab[ch] = TT;
                    1: chTab[ch] = 4'h0;
                    2: chTab[ch] = 4'hF;
                    default: chTab[ch] = 4'($urandom);
                endcase
            end
            s = 1'($urandom);
            l = 1'($urandom);
            if (l) ab = pickAbort(1, 80);
            else if ($urandom_range(0, 2) == 0) ab = pickAbort(1, 23);
            else ab = 0;
            applyStimulus($sformatf("rnd%0d", n), s, l, ab, $urandom_range(2, 20), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
